ibex_pext_mul_seq: RTL and testbench
====================================

Name: ibex_pext_mul_seq

Overview:
- Multi-cycle execution unit for the P-ext 16x16 signed multiply / multiply-accumulate group.
- Sits directly downstream of the P-ext decoder. It consumes the decoded zpn_op_e operator whenever the decoder's mult-select is set and the operator is in the 16x16 group.
- Uses one shared 17x17 signed multiplier, iterated over at most two lane products, with a 34-bit accumulator and optional 32-bit saturation.
- Returns result and OV-flag update to the EX stage through a valid/ready handshake.

Parameters:
- none

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  operation request
- ready_o  out  1  block can accept a request
- zpn_operator_i  in  zpn_op_e  decoded operator
- op_a_i  in  32  rs1
- op_b_i  in  32  rs2
- op_c_i  in  32  rd old value (accumulator source)
- kill_i  in  1  flush of in-flight operation
- valid_o  out  1  result available
- ready_i  in  1  consumer takes result
- result_o  out  32  result
- ov_o  out  1  saturation occurred; OV flag set request, qualified by valid_o

Behaviour:
- Lane notation: xB = x[15:0], xT = x[31:16], all signed. Each product is 32-bit signed. The accumulator is 34-bit signed.
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Operator table (init value; P0; P1; sat = saturating):
  - SMBB16: 0; aB*bB; -; no
  - SMBT16: 0; aB*bT; -; no
  - SMTT16: 0; aT*bT; -; no
  - KMDA: 0; +aT*bT; +aB*bB; sat
  - KMXDA: 0; +aT*bB; +aB*bT; sat
  - SMDS: 0; +aT*bT; -aB*bB; no
  - SMDRS: 0; +aB*bB; -aT*bT; no
  - SMXDS: 0; +aT*bB; -aB*bT; no
  - KMABB: c; +aB*bB; -; sat
  - KMABT: c; +aB*bT; -; sat
  - KMATT: c; +aT*bT; -; sat
  - KMADA: c; +aT*bT; +aB*bB; sat
  - KMAXDA: c; +aT*bB; +aB*bT; sat
  - KMADS: c; +aT*bT; -aB*bB; sat
  - KMADRS: c; +aB*bB; -aT*bT; sat
  - KMAXDS: c; +aT*bB; -aB*bT; sat
  - KMSDA: c; -aT*bT; -aB*bB; sat
  - KMSXDA: c; -aT*bB; -aB*bT; sat
- Any other operator that is accepted: result 0, ov 0, single-product timing.
- FSM states: IDLE, MUL0, MUL1, RESULT.
  - IDLE: ready_o=1. On valid_i & ~kill_i: latch operands and operator; acc <= sign-extended init value; go to MUL0.
  - MUL0: acc <= acc ± P0. Go to MUL1 if the op has P1, else RESULT.
  - MUL1: acc <= acc ± P1; go to RESULT.
  - RESULT: valid_o=1. Saturating ops: acc > 0x7FFFFFFF gives 0x7FFFFFFF with ov_o=1; acc < -2^31 gives 0x80000000 with ov_o=1; otherwise acc[31:0] with ov_o=0. Non-saturating ops: acc[31:0] (wraps), ov_o=0. On ready_i: go to IDLE.
- result_o and ov_o are registered and stable while valid_o=1 and ready_i=0.
- Latency from accept edge N: single-product op has valid_o high in cycle N+2; dual-product op in cycle N+3.
- ready_o=0 in MUL0, MUL1 and RESULT. valid_i in those states is ignored. There is no back-to-back accept in the same cycle as result handoff.
- kill_i (any state): next state IDLE, valid_o=0 next cycle, pending result discarded, no ov. If kill_i and valid_i are both high in IDLE, kill wins and the request is not accepted.
- Reset values: state IDLE, valid_o=0, ready_o=1 (after reset), result_o=0, ov_o=0, accumulator 0. rst_i mid-operation behaves like kill_i and also clears result_o and ov_o.
- Intermediate sum of the two products: -2^31 * 2 still fits in 34 bits. No internal overflow is possible, including the KMSDA path with c = -2^31.

Test Plan:
- SMBB16, a=0x0003FFFE, b=0x00000005, accept at N -> valid_o at N+2, result_o=0xFFFFFFF6, ov_o=0.
- KMDA, a=b=0x80008000 -> valid_o at N+3, result_o=0x7FFFFFFF, ov_o=1. Same inputs with SMDS -> result_o=0x00000000, ov_o=0.
- KMADA, c=0x7FFFFFF0, a=b=0x00010001 -> result_o=0x7FFFFFF2, ov_o=0. Repeat with c=0x7FFFFFFF -> result_o=0x7FFFFFFF, ov_o=1.
- SMDS, a=0x00020003, b=0x00040005 -> result_o=0xFFFFFFF9 (2*4-3*5=-7). SMDRS with the same inputs -> 0x00000007.
- Backpressure: hold ready_i=0 for 3 cycles in RESULT while toggling valid_i and operands -> result_o, ov_o and valid_o stay stable, ready_o=0, no new accept. ready_i=1 -> ready_o=1 the next cycle.
- Flush: assert kill_i during MUL1 of KMSDA -> valid_o never rises, ready_o=1 the next cycle. Assert rst_i in RESULT -> next cycle valid_o=0, result_o=0, ov_o=0.

Source files
------------

// File: rtl/ibex_pext_mul_seq_if.sv
// P-ext 16x16 multiply unit: operator encoding and the request/response
// interface (master = EX stage side, slave = multiplier side).
package ibex_pext_pkg;

  typedef enum logic [4:0] {
    ZPN_SMBB16,
    ZPN_SMBT16,
    ZPN_SMTT16,
    ZPN_KMDA,
    ZPN_KMXDA,
    ZPN_SMDS,
    ZPN_SMDRS,
    ZPN_SMXDS,
    ZPN_KMABB,
    ZPN_KMABT,
    ZPN_KMATT,
    ZPN_KMADA,
    ZPN_KMAXDA,
    ZPN_KMADS,
    ZPN_KMADRS,
    ZPN_KMAXDS,
    ZPN_KMSDA,
    ZPN_KMSXDA,
    ZPN_ADD16,
    ZPN_SUB16
  } zpn_op_e;

  // Per-product lane selects (t = top half), negate flags, and
  // op attributes: dual product, saturate, init from c, zero result.
  typedef struct packed {
    logic a0t;
    logic b0t;
    logic n0;
    logic a1t;
    logic b1t;
    logic n1;
    logic dual;
    logic sat;
    logic acc;
    logic zero;
  } mul_ctl_t;

endpackage

interface ibex_pext_mul_seq_if;
  logic                     valid_i;
  logic                     ready_o;
  ibex_pext_pkg::zpn_op_e   zpn_operator_i;
  logic [31:0]              op_a_i;
  logic [31:0]              op_b_i;
  logic [31:0]              op_c_i;
  logic                     kill_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [31:0]              result_o;
  logic                     ov_o;

  modport master (
    output valid_i, zpn_operator_i,
    output op_a_i, op_b_i, op_c_i,
    output kill_i, ready_i,
    input  ready_o, valid_o,
    input  result_o, ov_o
  );

  modport slave (
    input  valid_i, zpn_operator_i,
    input  op_a_i, op_b_i, op_c_i,
    input  kill_i, ready_i,
    output ready_o, valid_o,
    output result_o, ov_o
  );
endinterface

// File: rtl/ibex_pext_mul_seq.sv
// Sequential P-ext 16x16 signed multiply/MAC unit: one shared 17x17
// multiplier, 34-bit accumulator, optional 32-bit saturation.
// Ports: clk_i, rst_i (sync, active-high), bus (slave: request
// valid/ready + operator/operands, kill, response valid/ready + result/ov).
module ibex_pext_mul_seq
  import ibex_pext_pkg::*;
(
  input logic              clk_i,
  input logic              rst_i,
  ibex_pext_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL0,
    MUL1,
    RESULT
  } state_e;

  function automatic mul_ctl_t dec(zpn_op_e op);
    logic [9:0] c;
    unique case (op)
      ZPN_SMBB16: c = 10'b0000000000;
      ZPN_SMBT16: c = 10'b0100000000;
      ZPN_SMTT16: c = 10'b1100000000;
      ZPN_KMDA:   c = 10'b1100001100;
      ZPN_KMXDA:  c = 10'b1000101100;
      ZPN_SMDS:   c = 10'b1100011000;
      ZPN_SMDRS:  c = 10'b0001111000;
      ZPN_SMXDS:  c = 10'b1000111000;
      ZPN_KMABB:  c = 10'b0000000110;
      ZPN_KMABT:  c = 10'b0100000110;
      ZPN_KMATT:  c = 10'b1100000110;
      ZPN_KMADA:  c = 10'b1100001110;
      ZPN_KMAXDA: c = 10'b1000101110;
      ZPN_KMADS:  c = 10'b1100011110;
      ZPN_KMADRS: c = 10'b0001111110;
      ZPN_KMAXDS: c = 10'b1000111110;
      ZPN_KMSDA:  c = 10'b1110011110;
      ZPN_KMSXDA: c = 10'b1010111110;
      default:    c = 10'b0000000001;
    endcase
    return mul_ctl_t'(c);
  endfunction

  state_e       state_q, state_d;
  mul_ctl_t     ctl_q, ctl_d, ctl_in;
  logic [31:0]  a_q, a_d, b_q, b_d;
  logic [33:0]  acc_q, acc_d;
  logic [31:0]  res_q, res_d;
  logic         ov_q, ov_d;

  logic         sel_at, sel_bt, neg;
  logic [15:0]  la, lb;
  logic [33:0]  ma, mb, prod, acc_sum;
  logic [31:0]  sat_res;
  logic         sat_ov;

  assign ctl_in = dec(bus.zpn_operator_i);

  // Lane selection for whichever product this cycle computes.
  assign sel_at = (state_q == MUL1) ? ctl_q.a1t : ctl_q.a0t;
  assign sel_bt = (state_q == MUL1) ? ctl_q.b1t : ctl_q.b0t;
  assign neg    = (state_q == MUL1) ? ctl_q.n1  : ctl_q.n0;

  assign la = sel_at ? a_q[31:16] : a_q[15:0];
  assign lb = sel_bt ? b_q[31:16] : b_q[15:0];
  assign ma = {{18{la[15]}}, la};
  assign mb = {{18{lb[15]}}, lb};

  assign prod    = ctl_q.zero ? 34'd0 : ma * mb;
  assign acc_sum = neg ? acc_q - prod : acc_q + prod;

  // Out of 32-bit range when bits 33..31 disagree.
  always_comb begin
    sat_res = acc_sum[31:0];
    sat_ov  = 1'b0;
    if (ctl_q.sat && !(&acc_sum[33:31] || ~|acc_sum[33:31])) begin
      sat_ov  = 1'b1;
      sat_res = acc_sum[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_comb begin
    state_d = state_q;
    ctl_d   = ctl_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          ctl_d   = ctl_in;
          a_d     = bus.op_a_i;
          b_d     = bus.op_b_i;
          acc_d   = ctl_in.acc ?
                    {{2{bus.op_c_i[31]}}, bus.op_c_i} : 34'd0;
          state_d = MUL0;
        end
      end
      MUL0: begin
        acc_d = acc_sum;
        if (ctl_q.dual) begin
          state_d = MUL1;
        end else begin
          res_d   = sat_res;
          ov_d    = sat_ov;
          state_d = RESULT;
        end
      end
      MUL1: begin
        acc_d   = acc_sum;
        res_d   = sat_res;
        ov_d    = sat_ov;
        state_d = RESULT;
      end
      RESULT: begin
        if (bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.kill_i) begin
      state_d = IDLE;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.ready_o  = (state_q == IDLE);
  assign bus.valid_o  = (state_q == RESULT);
  assign bus.result_o = res_q;
  assign bus.ov_o     = ov_q;

endmodule

// File: tb/tb_ibex_pext_mul_seq.sv
// Randomized and directed bench for ibex_pext_mul_seq against an
// arithmetic reference model of the 16x16 multiply/MAC operators.
module tb_ibex_pext_mul_seq;
  import ibex_pext_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_pext_mul_seq_if bus ();

  ibex_pext_mul_seq dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ov, result} from plain integer arithmetic.
  function automatic logic [32:0] model(zpn_op_e op,
      logic [31:0] a, logic [31:0] b, logic [31:0] c);
    longint aB, aT, bB, bT, cc, s;
    logic [63:0] u;
    bit sat;
    aB = $signed(a[15:0]);
    aT = $signed(a[31:16]);
    bB = $signed(b[15:0]);
    bT = $signed(b[31:16]);
    cc = $signed(c);
    sat = 1'b1;
    case (op)
      ZPN_SMBB16: begin s = aB*bB; sat = 0; end
      ZPN_SMBT16: begin s = aB*bT; sat = 0; end
      ZPN_SMTT16: begin s = aT*bT; sat = 0; end
      ZPN_KMDA:   s = aT*bT + aB*bB;
      ZPN_KMXDA:  s = aT*bB + aB*bT;
      ZPN_SMDS:   begin s = aT*bT - aB*bB; sat = 0; end
      ZPN_SMDRS:  begin s = aB*bB - aT*bT; sat = 0; end
      ZPN_SMXDS:  begin s = aT*bB - aB*bT; sat = 0; end
      ZPN_KMABB:  s = cc + aB*bB;
      ZPN_KMABT:  s = cc + aB*bT;
      ZPN_KMATT:  s = cc + aT*bT;
      ZPN_KMADA:  s = cc + aT*bT + aB*bB;
      ZPN_KMAXDA: s = cc + aT*bB + aB*bT;
      ZPN_KMADS:  s = cc + aT*bT - aB*bB;
      ZPN_KMADRS: s = cc + aB*bB - aT*bT;
      ZPN_KMAXDS: s = cc + aT*bB - aB*bT;
      ZPN_KMSDA:  s = cc - aT*bT - aB*bB;
      ZPN_KMSXDA: s = cc - aT*bB - aB*bT;
      default:    begin s = 0; sat = 0; end
    endcase
    u = s;
    if (sat && s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (sat && s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, u[31:0]};
  endfunction

  function automatic bit is_dual(zpn_op_e op);
    return op inside {ZPN_KMDA, ZPN_KMXDA, ZPN_SMDS, ZPN_SMDRS,
                      ZPN_SMXDS, ZPN_KMADA, ZPN_KMAXDA, ZPN_KMADS,
                      ZPN_KMADRS, ZPN_KMAXDS, ZPN_KMSDA,
                      ZPN_KMSXDA};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] edge_v [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  function automatic logic [31:0] rnd32();
    return {rnd16(), rnd16()};
  endfunction

  // Issue one op, check ready, latency, result and ov; optionally
  // complete the handshake and check return to idle.
  task automatic run_op(input zpn_op_e op,
                        input logic [31:0] a, b, c,
                        input bit hs,
                        output logic [31:0] r,
                        output logic o);
    logic [32:0] e;
    int lat;
    bit seen;
    e = model(op, a, b, c);
    @(negedge clk);
    chk("ready_before", bus.ready_o, 1);
    bus.valid_i        = 1'b1;
    bus.zpn_operator_i = op;
    bus.op_a_i         = a;
    bus.op_b_i         = b;
    bus.op_c_i         = c;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.op_a_i  = rnd32();
    bus.op_b_i  = rnd32();
    bus.op_c_i  = rnd32();
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk("valid_seen", seen, 1);
    chk("latency", lat, is_dual(op) ? 3 : 2);
    chk("result", bus.result_o, e[31:0]);
    chk("ov", bus.ov_o, e[32]);
    r = bus.result_o;
    o = bus.ov_o;
    if (hs) begin
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ready_i = 1'b0;
      @(negedge clk);
      chk("valid_after_hs", bus.valid_o, 0);
      chk("ready_after_hs", bus.ready_o, 1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic o;
    zpn_op_e ops [20] = '{
      ZPN_SMBB16, ZPN_SMBT16, ZPN_SMTT16, ZPN_KMDA, ZPN_KMXDA,
      ZPN_SMDS, ZPN_SMDRS, ZPN_SMXDS, ZPN_KMABB, ZPN_KMABT,
      ZPN_KMATT, ZPN_KMADA, ZPN_KMAXDA, ZPN_KMADS, ZPN_KMADRS,
      ZPN_KMAXDS, ZPN_KMSDA, ZPN_KMSXDA, ZPN_ADD16, ZPN_SUB16};

    bus.valid_i        = 1'b0;
    bus.zpn_operator_i = ZPN_SMBB16;
    bus.op_a_i         = '0;
    bus.op_b_i         = '0;
    bus.op_c_i         = '0;
    bus.kill_i         = 1'b0;
    bus.ready_i        = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_ov", bus.ov_o, 0);

    // Directed cases with hand-computed values.
    run_op(ZPN_SMBB16, 32'h0003FFFE, 32'h5, 0, 1, r, o);
    chk("smbb16_k", {o, r}, {1'b0, 32'hFFFFFFF6});
    run_op(ZPN_KMDA, 32'h80008000, 32'h80008000, 0, 1, r, o);
    chk("kmda_k", {o, r}, {1'b1, 32'h7FFFFFFF});
    run_op(ZPN_SMDS, 32'h80008000, 32'h80008000, 0, 1, r, o);
    chk("smds_k", {o, r}, {1'b0, 32'h0});
    run_op(ZPN_KMADA, 32'h00010001, 32'h00010001, 32'h7FFFFFF0,
           1, r, o);
    chk("kmada_k", {o, r}, {1'b0, 32'h7FFFFFF2});
    run_op(ZPN_KMADA, 32'h00010001, 32'h00010001, 32'h7FFFFFFF,
           1, r, o);
    chk("kmada_sat_k", {o, r}, {1'b1, 32'h7FFFFFFF});
    run_op(ZPN_SMDS, 32'h00020003, 32'h00040005, 0, 1, r, o);
    chk("smds2_k", {o, r}, {1'b0, 32'hFFFFFFF9});
    run_op(ZPN_SMDRS, 32'h00020003, 32'h00040005, 0, 1, r, o);
    chk("smdrs_k", {o, r}, {1'b0, 32'h00000007});
    run_op(ZPN_KMSDA, 32'h80008000, 32'h80008000, 32'h80000000,
           1, r, o);
    chk("kmsda_neg_k", {o, r}, {1'b1, 32'h80000000});
    run_op(ZPN_ADD16, 32'h12345678, 32'h9ABCDEF0, 32'h1, 1, r, o);
    chk("other_op_k", {o, r}, {1'b0, 32'h0});

    // Backpressure: result held while ready_i low.
    run_op(ZPN_KMDA, 32'h80008000, 32'h80008000, 0, 0, r, o);
    for (int i = 0; i < 3; i++) begin
      bus.valid_i        = 1'b1;
      bus.zpn_operator_i = ops[$urandom_range(0, 19)];
      bus.op_a_i         = rnd32();
      bus.op_b_i         = rnd32();
      @(negedge clk);
      chk("bp_valid", bus.valid_o, 1);
      chk("bp_ready", bus.ready_o, 0);
      chk("bp_result", bus.result_o, 32'h7FFFFFFF);
      chk("bp_ov", bus.ov_o, 1);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", bus.ready_o, 1);
    chk("bp_release_valid", bus.valid_o, 0);

    // Kill during MUL1 of KMSDA.
    @(negedge clk);
    bus.valid_i        = 1'b1;
    bus.zpn_operator_i = ZPN_KMSDA;
    bus.op_a_i         = 32'h12345678;
    bus.op_b_i         = 32'h11112222;
    bus.op_c_i         = 32'h80000000;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    @(negedge clk);
    chk("kill_ready", bus.ready_o, 1);
    begin
      bit any_v = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (bus.valid_o) any_v = 1'b1;
        @(negedge clk);
      end
      chk("kill_no_valid", any_v, 0);
    end

    // Kill and valid together in idle: not accepted.
    bus.valid_i = 1'b1;
    bus.kill_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    @(negedge clk);
    chk("killvalid_ready", bus.ready_o, 1);
    repeat (3) @(negedge clk);
    chk("killvalid_no_valid", bus.valid_o, 0);

    // Reset while holding a saturated result.
    run_op(ZPN_KMDA, 32'h80008000, 32'h80008000, 0, 0, r, o);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", bus.valid_o, 0);
    chk("rst_mid_result", bus.result_o, 0);
    chk("rst_mid_ov", bus.ov_o, 0);
    chk("rst_mid_ready", bus.ready_o, 1);

    // Random sweep over all operators.
    for (int n = 0; n < 300; n++) begin
      run_op(ops[$urandom_range(0, 19)], rnd32(), rnd32(), rnd32(),
             1, r, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
